// File: rtl/jt49_nch_if.sv
// CPU-side register bus of the jt49_nch PSG core.
// Carries address, active-low chip select and write strobe, write data and registered read data.
interface jt49_nch_if;
  logic [4:0] addr;
  logic       cs_n;
  logic       wr_n;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output addr, cs_n, wr_n, din, input dout);
  modport slave  (input addr, cs_n, wr_n, din, output dout);
endinterface

// File: rtl/jt49_nch.sv
// jt49_nch: N-channel PSG core with square tones, shared LFSR noise, shared envelope and a log DAC per channel.
// Define PSG_STEREO_EN to add the pan register (0x18/0x19) and the snd_l/snd_r outputs.
//
// env state | meaning
// E_HOLD    | envelope frozen (after reset, or at cycle end when CONT=0 or HOLD=1)
// E_RUN     | envelope steps once per divider rollover, 32 steps per cycle
module jt49_nch #(
  parameter int NCH = 3,
  parameter int PW  = 12,
  parameter int EW  = 16,
  localparam int SW = 8 + $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             sel,
  jt49_nch_if.slave        bus,
  output logic [8*NCH-1:0] chan,
  output logic [SW-1:0]    sound
`ifdef PSG_STEREO_EN
  ,
  output logic [SW-1:0]    snd_l,
  output logic [SW-1:0]    snd_r
`endif
);

  typedef enum logic {E_HOLD = 1'b0, E_RUN = 1'b1} env_st_t;

  localparam logic [7:0] T_HI_MASK = 8'((32'd1 << (PW - 8)) - 32'd1);
  localparam logic [7:0] E_HI_MASK = 8'((32'd1 << (EW - 8)) - 32'd1);
  localparam logic [0:31][7:0] LIN = {
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
  };

  logic [7:0]     tper_lo [NCH];
  logic [7:0]     tper_hi [NCH];
  logic [4:0]     vol     [NCH];
  logic [4:0]     nper;
  logic [NCH-1:0] tdis;
  logic [NCH-1:0] ndis;
  logic [7:0]     eper_lo;
  logic [7:0]     eper_hi;
  logic [3:0]     eshape;
`ifdef PSG_STEREO_EN
  localparam logic [15:0] PAN_MASK = 16'((32'd1 << (2 * NCH)) - 32'd1);
  logic [15:0]    pan;
`endif

  logic       wr;
  logic       env_wr;
  logic [3:0] shape_nx;
  logic [7:0] rdata;

  assign wr       = !bus.cs_n && !bus.wr_n;
  assign env_wr   = wr && (bus.addr == 5'h17);
  // a shape write coinciding with a tick restarts with the new shape
  assign shape_nx = env_wr ? bus.din[3:0] : eshape;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.addr == 5'(2 * i))     rdata = tper_lo[i];
      if (bus.addr == 5'(2 * i + 1)) rdata = tper_hi[i];
      if (bus.addr == 5'(15 + i))    rdata = {3'b000, vol[i]};
    end
    case (bus.addr)
      5'h0C:   rdata = {3'b000, nper};
      5'h0D:   rdata = 8'(tdis);
      5'h0E:   rdata = 8'(ndis);
      5'h15:   rdata = eper_lo;
      5'h16:   rdata = eper_hi;
      5'h17:   rdata = {4'h0, eshape};
`ifdef PSG_STEREO_EN
      5'h18:   rdata = pan[7:0];
      5'h19:   rdata = pan[15:8];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        tper_lo[i] <= '0;
        tper_hi[i] <= '0;
        vol[i]     <= '0;
      end
      nper     <= '0;
      tdis     <= '0;
      ndis     <= '0;
      eper_lo  <= '0;
      eper_hi  <= '0;
      eshape   <= '0;
`ifdef PSG_STEREO_EN
      pan      <= '0;
`endif
      bus.dout <= '0;
    end else begin
      if (!bus.cs_n) bus.dout <= rdata;
      if (wr) begin
        for (int i = 0; i < NCH; i++) begin
          if (bus.addr == 5'(2 * i))     tper_lo[i] <= bus.din;
          if (bus.addr == 5'(2 * i + 1)) tper_hi[i] <= bus.din & T_HI_MASK;
          if (bus.addr == 5'(15 + i))    vol[i]     <= bus.din[4:0];
        end
        case (bus.addr)
          5'h0C:   nper    <= bus.din[4:0];
          5'h0D:   tdis    <= bus.din[NCH-1:0];
          5'h0E:   ndis    <= bus.din[NCH-1:0];
          5'h15:   eper_lo <= bus.din;
          5'h16:   eper_hi <= bus.din & E_HI_MASK;
          5'h17:   eshape  <= bus.din[3:0];
`ifdef PSG_STEREO_EN
          5'h18:   pan[7:0]  <= bus.din & PAN_MASK[7:0];
          5'h19:   pan[15:8] <= bus.din & PAN_MASK[15:8];
`endif
          default: ;
        endcase
      end
    end
  end

  // Prescaler: terminal count at zero gives the generator tick
  logic [3:0] pre;
  logic       cen_ch;
  assign cen_ch = cen && (pre == 4'd0);

  logic [PW-1:0] tper [NCH];
  logic [PW-1:0] tlim [NCH];
  logic [4:0]    nlim;
  logic [EW-1:0] eper;
  logic [EW-1:0] elim;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tper[i] = PW'({tper_hi[i], tper_lo[i]});
      tlim[i] = (tper[i] == '0) ? '0 : tper[i] - PW'(1);
    end
    nlim = (nper == 5'd0) ? 5'd0 : nper - 5'd1;
    eper = EW'({eper_hi, eper_lo});
    elim = (eper == '0) ? '0 : eper - EW'(1);
  end

  logic [PW-1:0]  tcnt [NCH];
  logic [NCH-1:0] tone;
  logic [4:0]     ncnt;
  logic [16:0]    lfsr;
  logic [EW-1:0]  ecnt;
  logic [4:0]     estep;
  logic [4:0]     env;
  logic           edir;
  logic           env_pend;
  env_st_t        est;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre      <= '0;
      for (int i = 0; i < NCH; i++) tcnt[i] <= '0;
      tone     <= '0;
      ncnt     <= '0;
      lfsr     <= 17'h1;
      ecnt     <= '0;
      estep    <= '0;
      env      <= '0;
      edir     <= 1'b0;
      env_pend <= 1'b0;
      est      <= E_HOLD;
    end else begin
      if (cen) pre <= (pre == 4'd0) ? (sel ? 4'd7 : 4'd15) : pre - 4'd1;

      if (cen_ch)      env_pend <= 1'b0;
      else if (env_wr) env_pend <= 1'b1;

      if (cen_ch) begin
        // >= rather than == so a period lowered below the count ends the cycle at once
        for (int i = 0; i < NCH; i++) begin
          if (tcnt[i] >= tlim[i]) begin
            tcnt[i] <= '0;
            tone[i] <= ~tone[i];
          end else begin
            tcnt[i] <= tcnt[i] + PW'(1);
          end
        end

        if (ncnt >= nlim) begin
          ncnt <= '0;
          lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
        end else begin
          ncnt <= ncnt + 5'd1;
        end

        if (env_pend || env_wr) begin
          ecnt  <= '0;
          estep <= '0;
          edir  <= shape_nx[2];
          env   <= shape_nx[2] ? 5'd0 : 5'd31;
          est   <= E_RUN;
        end else if (est == E_RUN) begin
          if (ecnt >= elim) begin
            ecnt <= '0;
            if (estep == 5'd31) begin
              estep <= '0;
              if (!eshape[3]) begin
                env <= 5'd0;
                est <= E_HOLD;
              end else if (eshape[0]) begin
                env <= (eshape[2] ^ eshape[1]) ? 5'd31 : 5'd0;
                est <= E_HOLD;
              end else begin
                edir <= edir ^ eshape[1];
                env  <= (edir ^ eshape[1]) ? 5'd0 : 5'd31;
              end
            end else begin
              estep <= estep + 5'd1;
              env   <= edir ? env + 5'd1 : env - 5'd1;
            end
          end else begin
            ecnt <= ecnt + EW'(1);
          end
        end
      end
    end
  end

  logic [4:0]    level [NCH];
  logic [SW-1:0] sum_c;
`ifdef PSG_STEREO_EN
  logic [SW-1:0] sum_l;
  logic [SW-1:0] sum_r;
`endif

  always_comb begin
    sum_c = '0;
`ifdef PSG_STEREO_EN
    sum_l = '0;
    sum_r = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      sum_c = sum_c + SW'(chan[8*i +: 8]);
`ifdef PSG_STEREO_EN
      // pan {R,L}: one bit set selects that side only, 00 or 11 feeds both
      if (pan[2*i] || !pan[2*i+1]) sum_l = sum_l + SW'(chan[8*i +: 8]);
      if (pan[2*i+1] || !pan[2*i]) sum_r = sum_r + SW'(chan[8*i +: 8]);
`endif
    end
  end

  // Mixer -> DAC -> sum, one register each on cen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) level[i] <= '0;
      chan  <= '0;
      sound <= '0;
`ifdef PSG_STEREO_EN
      snd_l <= '0;
      snd_r <= '0;
`endif
    end else if (cen) begin
      for (int i = 0; i < NCH; i++) begin
        if ((tone[i] | tdis[i]) & (lfsr[0] | ndis[i]))
          level[i] <= vol[i][4] ? env : {vol[i][3:0], vol[i][3]};
        else
          level[i] <= 5'd0;
        chan[8*i +: 8] <= LIN[level[i]];
      end
      sound <= sum_c;
`ifdef PSG_STEREO_EN
      snd_l <= sum_l;
      snd_r <= sum_r;
`endif
    end
  end

endmodule

// File: tb/tb_jt49_nch.sv
// Directed bench for jt49_nch: register map, tone timing, noise sequence, envelope shapes and channel sums.
module tb_jt49_nch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic sel = 1'b1;

  jt49_nch_if bus3();
  jt49_nch_if bus6();

  logic [23:0] chan3;
  logic [9:0]  sound3;
  logic [47:0] chan6;
  logic [10:0] sound6;
`ifdef PSG_STEREO_EN
  logic [9:0]  snd_l3, snd_r3;
  logic [10:0] snd_l6, snd_r6;
`endif

  jt49_nch #(.NCH(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sel(sel), .bus(bus3),
    .chan(chan3), .sound(sound3)
`ifdef PSG_STEREO_EN
    , .snd_l(snd_l3), .snd_r(snd_r3)
`endif
  );

  jt49_nch #(.NCH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sel(sel), .bus(bus6),
    .chan(chan6), .sound(sound6)
`ifdef PSG_STEREO_EN
    , .snd_l(snd_l6), .snd_r(snd_r6)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] lin_tab [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
  };

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus3.addr = a; bus3.din = d; bus3.cs_n = 1'b0; bus3.wr_n = 1'b0;
    bus6.addr = a; bus6.din = d; bus6.cs_n = 1'b0; bus6.wr_n = 1'b0;
    @(negedge clk);
    bus3.cs_n = 1'b1; bus3.wr_n = 1'b1;
    bus6.cs_n = 1'b1; bus6.wr_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    bus3.addr = a; bus3.cs_n = 1'b0; bus3.wr_n = 1'b1;
    @(negedge clk);
    d = bus3.dout;
    bus3.cs_n = 1'b1;
  endtask

  task automatic pulse_cen(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) cen = 1'b1;
      @(negedge clk) cen = 1'b0;
    end
  endtask

  task automatic do_reset();
    cen = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Envelope value j ticks after a restart with shape sh (tick 1 is the restart itself)
  function automatic int env_exp(input logic [3:0] sh, input int j);
    int cyc;
    int pos;
    logic up;
    cyc = (j - 1) / 32;
    pos = (j - 1) % 32;
    up  = sh[2];
    if (cyc > 0 && (!sh[3] || sh[0]))
      return (!sh[3]) ? 0 : ((sh[2] ^ sh[1]) ? 31 : 0);
    if (sh[1] && (cyc % 2 == 1)) up = ~up;
    return up ? pos : 31 - pos;
  endfunction

  task automatic env_run(input logic [3:0] sh, input int n);
    wr(5'h17, {4'h0, sh});
    for (int j = 1; j <= n; j++) begin
      pulse_cen(8);
      check($sformatf("env_%0h_t%0d", sh, j), chan3[7:0], lin_tab[env_exp(sh, j)]);
    end
  endtask

  typedef struct { logic [4:0] a; logic [7:0] w; logic [7:0] r; } reg_vec_t;
  reg_vec_t rv [13];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int exp_c, exp_s, prev, errs;
    logic [16:0] m;

    bus3.cs_n = 1'b1; bus3.wr_n = 1'b1; bus3.addr = '0; bus3.din = '0;
    bus6.cs_n = 1'b1; bus6.wr_n = 1'b1; bus6.addr = '0; bus6.din = '0;

    // reset state
    do_reset();
    check("rst_chan", chan3, 0);
    check("rst_sound", sound3, 0);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), d);
      check($sformatf("rst_rd_%0h", a), d, 0);
    end

    // register map, masking, absent channels, unmapped addresses
    rv[0]  = '{5'h02, 8'hFF, 8'hFF};
    rv[1]  = '{5'h03, 8'hFF, 8'h0F};
    rv[2]  = '{5'h06, 8'hFF, 8'h00};
    rv[3]  = '{5'h0C, 8'hFF, 8'h1F};
    rv[4]  = '{5'h0D, 8'hFF, 8'h07};
    rv[5]  = '{5'h0E, 8'hAA, 8'h02};
    rv[6]  = '{5'h11, 8'hFF, 8'h1F};
    rv[7]  = '{5'h12, 8'hFF, 8'h00};
    rv[8]  = '{5'h15, 8'h5A, 8'h5A};
    rv[9]  = '{5'h16, 8'hFF, 8'hFF};
    rv[10] = '{5'h17, 8'hFF, 8'h0F};
`ifdef PSG_STEREO_EN
    rv[11] = '{5'h18, 8'hFF, 8'h3F};
`else
    rv[11] = '{5'h18, 8'hFF, 8'h00};
`endif
    rv[12] = '{5'h1F, 8'hFF, 8'h00};
    foreach (rv[i]) wr(rv[i].a, rv[i].w);
    foreach (rv[i]) begin
      rd(rv[i].a, d);
      check($sformatf("reg_%0h", rv[i].a), d, rv[i].r);
    end

    // tone 0, period 2, sel=1: 16-cen half period after 11-cen start-up
    do_reset();
    sel = 1'b1;
    wr(5'h00, 8'd2); wr(5'h0D, 8'h00); wr(5'h0E, 8'h07); wr(5'h0F, 8'h0F);
    prev = 0;
    for (int k = 1; k <= 80; k++) begin
      pulse_cen(1);
      exp_c = (k >= 11 && ((k - 11) % 32) < 16) ? 255 : 0;
      check($sformatf("tone0_c%0d", k), chan3[7:0], exp_c);
      check($sformatf("tone0_snd%0d", k), sound3, prev);
      prev = exp_c;
    end

    // tone 1, period 1, sel=0, volume 8 (level 17); ch0 forced on at full scale
    do_reset();
    sel = 1'b0;
    wr(5'h02, 8'd1); wr(5'h0D, 8'h01); wr(5'h0E, 8'h07); wr(5'h0F, 8'h0F); wr(5'h10, 8'h08);
    prev = 0;
    for (int k = 1; k <= 50; k++) begin
      pulse_cen(1);
      exp_c = (k >= 3 && ((k - 3) % 32) < 16) ? 23 : 0;
      exp_s = (k >= 2) ? 255 : 0;
      check($sformatf("tone1_c%0d", k), chan3[15:8], exp_c);
      check($sformatf("ch0_on_c%0d", k), chan3[7:0], exp_s);
      check($sformatf("tone1_snd%0d", k), sound3, prev);
      prev = exp_c + exp_s;
    end

    // noise period 1 against a reference LFSR from 17'h1
    do_reset();
    sel = 1'b1;
    wr(5'h0D, 8'h07); wr(5'h0E, 8'h06); wr(5'h0F, 8'h0F); wr(5'h0C, 8'h01);
    m = 17'h1;
    errs = 0;
    for (int j = 1; j <= 1000; j++) begin
      pulse_cen(8);
      m = {m[0] ^ m[3], m[16:1]};
      if (chan3[7:0] != (m[0] ? 8'd255 : 8'd0)) errs++;
    end
    check("noise_seq_errs", errs, 0);

    // envelope shapes at period 1, restart mid-ramp, then reset mid-ramp
    do_reset();
    sel = 1'b1;
    wr(5'h0D, 8'h07); wr(5'h0E, 8'h07); wr(5'h0F, 8'h10); wr(5'h15, 8'h01);
    env_run(4'hE, 70);
    env_run(4'hE, 5);
    env_run(4'h9, 40);
    env_run(4'hD, 40);
    env_run(4'h4, 40);
    env_run(4'hE, 10);
    do_reset();
    check("env_rst_chan", chan3[7:0], 0);
    rd(5'h17, d);
    check("env_rst_shape", d, 0);
    wr(5'h0D, 8'h07); wr(5'h0E, 8'h07); wr(5'h0F, 8'h10); wr(5'h15, 8'h01);
    for (int j = 1; j <= 5; j++) begin
      pulse_cen(8);
      check($sformatf("env_held_t%0d", j), chan3[7:0], 0);
    end

    // all channels on at volume 15: full-scale sums, 3-cen latency
    do_reset();
    wr(5'h0D, 8'h3F); wr(5'h0E, 8'h3F);
    for (int i = 0; i < 6; i++) wr(5'(15 + i), 8'h0F);
`ifdef PSG_STEREO_EN
    wr(5'h18, 8'h01);
`endif
    pulse_cen(2);
    check("sum6_lat2", sound6, 0);
    check("ch5_lat2", chan6[47:40], 255);
    pulse_cen(1);
    check("sum6_full", sound6, 1530);
    check("sum3_full", sound3, 765);
`ifdef PSG_STEREO_EN
    check("pan_l", snd_l3, 765);
    check("pan_r", snd_r3, 510);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
